transform_decoder_4x4: RTL
==========================

Name: transform_decoder_4x4

Overview:
Decoder-side counterpart of the 4x4 transform coding chain. It accepts one block of 16 quantized levels plus its QP and applies H.264 inverse quantization. It then runs a row-then-column 4x4 inverse integer transform with final rounding. It returns 16 reconstructed residuals. It sits between the entropy decoder and the reconstruction adder, with a valid/ready handshake on both sides.

Parameters:
BIT_LENGTH, 31, MSB index of each signed coefficient/residual word (word width BIT_LENGTH+1).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  global advance; when 0, all state is frozen
QP  input  6  quantization parameter, sampled at input handshake
in_valid  input  1  levels and QP valid
in_ready  output  1  block can accept input
levels  input  [BIT_LENGTH:0] x16  signed quantized levels, index k = 4*row + col
out_valid  output  1  residuals valid
out_ready  input  1  downstream accepts residuals
residuals  output  [BIT_LENGTH:0] x16  signed reconstructed residuals, same indexing

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state IDLE; out_valid=0; all residuals=0; internal registers=0.
- in_ready = enable && state==IDLE (combinational).
- enable=0 freezes FSM, counters, data and outputs. in_ready reads 0. out_valid holds its value.
- FSM states:
  - IDLE: on in_valid && in_ready, capture levels. Capture qp = min(QP,51), which sets qp_rem=qp and qp_div=0. Go to DIV.
  - DIV: each cycle, if qp_rem>=6 then qp_rem-=6 and qp_div+=1. Otherwise go to DEQ. This takes floor(qp/6)+1 cycles.
  - DEQ: one cycle, all 16 in parallel: W[k] = (Z[k] * V(qp_rem,k)) << qp_div.
  - ROW: 4 cycles, one row per cycle, row counter 0..3. Writes back in place.
  - COL: 4 cycles, one column per cycle. Results r = (f + 32) >>> 6 are written to the residuals register. Then go to OUT and assert out_valid.
  - OUT: hold residuals and out_valid until out_valid && out_ready. Then deassert out_valid and go to IDLE, so in_ready=1 next cycle.
- V table, position class by k:
  - Class a: k in {0,2,8,10}.
  - Class b: k in {5,7,13,15}.
  - Class c: all other k.
  - Values (a,b,c) by qp_rem: 0:(10,16,13), 1:(11,18,14), 2:(13,20,16), 3:(14,23,18), 4:(16,25,20), 5:(18,29,23).
- Butterfly, inputs w0..w3:
  - e0=w0+w2, e1=w0-w2, e2=(w1>>>1)-w3, e3=w1+(w3>>>1).
  - Outputs f0=e0+e3, f1=e1+e2, f2=e1-e2, f3=e0-e3.
- Arithmetic: all signed two's complement in BIT_LENGTH+1 bits, with wraparound and no saturation. Shifts are arithmetic.
- Latency: out_valid rises 10+floor(qp/6) enabled cycles after the accepting edge.
- QP>51 is clamped to 51. A QP change after capture is ignored.
- Reset mid-operation abandons the block. Next cycle: IDLE, out_valid=0, residuals=0.
- Simultaneous reset and handshake: reset wins, nothing is captured.
- Throughput: one block in flight; no input acceptance outside IDLE.

Decomposition:
- Package transform_pkg holds:
  - The state enum (IDLE, DIV, DEQ, ROW, COL, OUT).
  - The V table as a 6x3 constant and the position-class function.
  - The QP_MAX=51 and ROUND_OFFSET=32 constants.
- Sub-module idct4_butterfly: combinational 4-point butterfly, parameterised on BIT_LENGTH. It is shared by the ROW and COL passes.

Test Plan:
- QP=0, levels[0]=64, rest 0 -> all 16 residuals=10 (640+32>>>6). out_valid 10 cycles after accept.
- QP=28, levels[0]=4 -> W0=4*16<<4=1024 -> all residuals=16. Latency 14 cycles.
- QP=0, levels[0]=-64 -> W0=-640 -> all residuals=-10 (arithmetic floor).
- QP=60 (clamped to 51, div 8, rem 3), levels[0]=1 -> W0=14<<8=3584 -> all residuals=56. Latency 18 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: residuals stable, out_valid=1, in_ready=0. After the out_ready handshake, out_valid=0 and in_ready=1 on the next cycle.
- Control: drop enable for 3 cycles during ROW; completion is delayed by exactly 3 cycles with identical results. Then assert reset during COL; next cycle out_valid=0, residuals all 0, in_ready=1.

Source files
------------

// File: rtl/transform_pkg.sv
// Shared types and constants for the 4x4 inverse transform decoder:
// FSM states, dequantisation scale table and coefficient position classes.
package transform_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_DEQ,
        ST_ROW,
        ST_COL,
        ST_OUT
    } state_t;

    localparam int QP_MAX       = 51;
    localparam int ROUND_OFFSET = 32;

    // Rows indexed by qp % 6, columns by position class (a, b, c).
    localparam logic [4:0] V_TAB [6][3] = '{
        '{5'd10, 5'd16, 5'd13},
        '{5'd11, 5'd18, 5'd14},
        '{5'd13, 5'd20, 5'd16},
        '{5'd14, 5'd23, 5'd18},
        '{5'd16, 5'd25, 5'd20},
        '{5'd18, 5'd29, 5'd23}
    };

    function automatic logic [1:0] pos_class(input logic [3:0] k);
        logic [1:0] cls;
        case (k)
            4'd0, 4'd2, 4'd8, 4'd10:   cls = 2'd0;
            4'd5, 4'd7, 4'd13, 4'd15:  cls = 2'd1;
            default:                   cls = 2'd2;
        endcase
        return cls;
    endfunction

    function automatic logic [4:0] v_coef(input logic [2:0] rem, input logic [3:0] k);
        return V_TAB[rem][pos_class(k)];
    endfunction

endpackage

// File: rtl/idct4_butterfly.sv
// Combinational 4-point inverse integer transform butterfly, shared by the
// row and column passes of the decoder.
module idct4_butterfly #(
    parameter int BIT_LENGTH = 31
) (
    input  logic signed [BIT_LENGTH:0] i_w [4],
    output logic signed [BIT_LENGTH:0] o_f [4]
);

    logic signed [BIT_LENGTH:0] w_e0, w_e1, w_e2, w_e3;

    assign w_e0 = i_w[0] + i_w[2];
    assign w_e1 = i_w[0] - i_w[2];
    assign w_e2 = (i_w[1] >>> 1) - i_w[3];
    assign w_e3 = i_w[1] + (i_w[3] >>> 1);

    assign o_f[0] = w_e0 + w_e3;
    assign o_f[1] = w_e1 + w_e2;
    assign o_f[2] = w_e1 - w_e2;
    assign o_f[3] = w_e0 - w_e3;

endmodule

// File: rtl/transform_decoder_4x4.sv
// H.264 4x4 decoder back end: inverse quantisation followed by a row-then-
// column inverse integer transform with final rounding, one block in flight.
module transform_decoder_4x4
    import transform_pkg::*;
#(
    parameter int BIT_LENGTH = 31
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [5:0]                 QP,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0][BIT_LENGTH:0]  levels,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0][BIT_LENGTH:0]  residuals
);

    localparam int W = BIT_LENGTH + 1;

    state_t                     r_state;
    logic [5:0]                 r_qp_rem;
    logic [3:0]                 r_qp_div;
    logic [1:0]                 r_cnt;
    logic [15:0][BIT_LENGTH:0]  r_data;
    logic [15:0][BIT_LENGTH:0]  r_res;
    logic                       r_out_valid;

    logic [15:0][BIT_LENGTH:0]  w_deq;
    logic signed [BIT_LENGTH:0] w_bf_in  [4];
    logic signed [BIT_LENGTH:0] w_bf_out [4];
    logic signed [BIT_LENGTH:0] w_rnd    [4];
    logic [3:0]                 w_idx    [4];

    assign in_ready  = enable && (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign residuals = r_res;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            logic signed [BIT_LENGTH:0] coef;
            coef     = W'(v_coef(r_qp_rem[2:0], 4'(k)));
            w_deq[k] = ($signed(r_data[k]) * coef) <<< r_qp_div;
        end
    end

    // Row pass walks index {cnt, i}; column pass walks {i, cnt}.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_idx[i]   = (r_state == ST_COL) ? {2'(i), r_cnt} : {r_cnt, 2'(i)};
            w_bf_in[i] = $signed(r_data[w_idx[i]]);
        end
    end

    idct4_butterfly #(.BIT_LENGTH(BIT_LENGTH)) u_bfly (
        .i_w (w_bf_in),
        .o_f (w_bf_out)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic signed [BIT_LENGTH:0] biased;
            biased   = w_bf_out[i] + W'(ROUND_OFFSET);
            w_rnd[i] = biased >>> 6;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_qp_rem    <= '0;
            r_qp_div    <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data   <= levels;
                        r_qp_rem <= (QP > 6'(QP_MAX)) ? 6'(QP_MAX) : QP;
                        r_qp_div <= '0;
                        r_state  <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (r_qp_rem >= 6'd6) begin
                        r_qp_rem <= r_qp_rem - 6'd6;
                        r_qp_div <= r_qp_div + 4'd1;
                    end else begin
                        r_state <= ST_DEQ;
                    end
                end
                ST_DEQ: begin
                    r_data  <= w_deq;
                    r_cnt   <= '0;
                    r_state <= ST_ROW;
                end
                ST_ROW: begin
                    for (int i = 0; i < 4; i++) r_data[w_idx[i]] <= w_bf_out[i];
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_state <= ST_COL;
                end
                ST_COL: begin
                    for (int i = 0; i < 4; i++) r_res[w_idx[i]] <= w_rnd[i];
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
